yzh_komut_denetleyici: RTL and testbench
========================================

# yzh_komut_denetleyici

Command controller placed between the decode stage and the AI accelerator. It decodes custom-0 convolution instructions, drives one-cycle load/clear/run control pulses and operand buses into the accelerator, and stalls the pipeline while `conv.run` executes. It also returns the convolution result to the writeback stage as a register write.

## Interface
- `ZAMAN_ASIMI` (default 64): `conv.run` cycle budget before a timeout. Only used when `YZH_ZAMAN_ASIMI_EN` is defined.
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `durdur_i`  in  1  pipeline freeze from downstream; forwarded unchanged on `durdur_o`
- `komut_gecerli_i`  in  1  `komut_i` holds a valid decoded instruction
- `komut_i`  in  32  raw instruction word
- `rs1_veri_i`, `rs2_veri_i`  in  32  register operands
- `conv_sonuc_i`  in  32  accelerator result
- `conv_hazir_i`  in  1  accelerator result valid
- `blok_aktif_o`  out  1  accelerator enable
- `filtre_rs1_en_o`, `filtre_rs2_en_o`, `filtre_sil_o`, `veri_rs1_en_o`, `veri_rs2_en_o`, `veri_sil_o`, `conv_yap_en_o`  out  1  accelerator controls
- `rs1_veri_o`, `rs2_veri_o`  out  32  registered operands to the accelerator
- `durdur_o`  out  1  equals `durdur_i`
- `stall_o`  out  1  freeze the fetch/decode stages
- `yaz_gecerli_o`  out  1  writeback request
- `yaz_adres_o`  out  5  destination register
- `yaz_veri_o`  out  32  writeback data
- `gecersiz_komut_o`  out  1  unsupported custom-0 funct3

## Operation
- Instruction match: `komut_i[6:0]==7'b0001011`.
- `funct3 = komut_i[14:12]`:
  - 000 `conv.ldw`: filter load
  - 001 `conv.clrw`: clear filter
  - 010 `conv.ldx`: data load
  - 011 `conv.clrx`: clear data
  - 100 `conv.run`: run convolution
  - 101–111: invalid
- `komut_i[25]=1` on a load selects a two-word load. The `*_rs1_en` and `*_rs2_en` outputs are then both 1. Otherwise only `rs1_en` is 1.
- FSM states:
  - BOSTA (idle)
  - CALISTIR (running)
  - SONUC (result)
- Acceptance condition: state BOSTA && `komut_gecerli_i` && opcode match && !`durdur_i`.
- Load/clear: on acceptance, the matching enable(s), `blok_aktif_o` and `rs1/rs2_veri_o` are registered. They are high for exactly the next cycle. The state stays BOSTA, so one load per cycle is sustained.
- Run, on acceptance:
  - Latch rd (`komut_i[11:7]`).
  - Go to CALISTIR.
  - In CALISTIR, `conv_yap_en_o=1`, `blok_aktif_o=1`, `stall_o=1`.
  - When `conv_hazir_i=1` in CALISTIR: latch `conv_sonuc_i` into `yaz_veri_o`, go to SONUC.
- SONUC:
  - `yaz_gecerli_o=1`, `stall_o=0`.
  - Leave to BOSTA on the first cycle with !`durdur_i`; the write completes that cycle.
  - While `durdur_i=1`, hold all outputs.
- Invalid funct3: `gecersiz_komut_o` pulses one cycle. There is no accelerator pulse and no write.
- rd=0 on run: the run still executes and writes back with `yaz_adres_o=0`.
- Non-custom instructions are ignored. All outputs stay at rest values.

## Timing
- Reset value of every output is 0; state BOSTA; timeout counter 0. Reset mid-run aborts it with no writeback.
- Load/clear latency: enable pulse 1 cycle after acceptance.
- Run latency: `yaz_gecerli_o` rises 1 cycle after the first `conv_hazir_i` sampled in CALISTIR.
- A `conv_hazir_i` already high on the CALISTIR entry cycle is taken immediately (min run = 2 cycles).
- `durdur_i` in CALISTIR:
  - Controls are held.
  - `conv_hazir_i` is still sampled.
  - The counter does not advance.
- `stall_o` is registered, not combinational from `komut_i`. The instruction following a run is held by decode because `stall_o` is high from the cycle after acceptance.
- `conv_hazir_i` outside CALISTIR is ignored.

## Configuration
- `YZH_ZAMAN_ASIMI_EN` defined:
  - A counter runs in CALISTIR.
  - When it reaches `ZAMAN_ASIMI` without `conv_hazir_i`, latch `yaz_veri_o=32'hFFFF_FFFF` and go to SONUC.
  - The counter clears on CALISTIR entry.
- Undefined: no counter; CALISTIR waits indefinitely.

## Test plan
- Reset while in CALISTIR -> next cycle all outputs 0, state BOSTA, no write.
- `conv.ldw` with `komut_i[25]=1`, rs1=0x11, rs2=0x22 -> next cycle: `filtre_rs1_en_o=1`, `filtre_rs2_en_o=1`, `rs1_veri_o=0x11`, `rs2_veri_o=0x22`; all enables 0 the cycle after.
- Four back-to-back `conv.ldx` single-word loads (rs1=1..4) -> four consecutive `veri_rs1_en_o` pulses; `stall_o` stays 0.
- `conv.run` rd=5, `conv_hazir_i` asserted 6 cycles later with 0x1234 -> `stall_o` high 6 cycles, `conv_yap_en_o` high throughout, then `yaz_gecerli_o=1`, `yaz_adres_o=5`, `yaz_veri_o=0x1234` for 1 cycle.
- Same run with `durdur_i=1` for 3 cycles in SONUC -> `yaz_gecerli_o` held 4 cycles, data stable; funct3=110 -> `gecersiz_komut_o` single pulse, no enables.
- With `YZH_ZAMAN_ASIMI_EN`, `ZAMAN_ASIMI=8`, `conv_hazir_i` never asserted -> write of 0xFFFFFFFF after 8 CALISTIR cycles.

Source files
------------

// File: rtl/yzh_komut_denetleyici.sv
// Command controller between decode and the convolution accelerator: decodes custom-0 conv.* instructions.
// Optional run timeout is enabled by defining YZH_ZAMAN_ASIMI_EN.
module yzh_komut_denetleyici #(
   parameter int ZAMAN_ASIMI = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        durdur_i,
   input  logic        komut_gecerli_i,
   input  logic [31:0] komut_i,
   input  logic [31:0] rs1_veri_i,
   input  logic [31:0] rs2_veri_i,
   input  logic [31:0] conv_sonuc_i,
   input  logic        conv_hazir_i,
   output logic        blok_aktif_o,
   output logic        filtre_rs1_en_o,
   output logic        filtre_rs2_en_o,
   output logic        filtre_sil_o,
   output logic        veri_rs1_en_o,
   output logic        veri_rs2_en_o,
   output logic        veri_sil_o,
   output logic        conv_yap_en_o,
   output logic [31:0] rs1_veri_o,
   output logic [31:0] rs2_veri_o,
   output logic        durdur_o,
   output logic        stall_o,
   output logic        yaz_gecerli_o,
   output logic [4:0]  yaz_adres_o,
   output logic [31:0] yaz_veri_o,
   output logic        gecersiz_komut_o
);

   typedef enum logic [1:0] {
      BOSTA    = 2'd0,
      CALISTIR = 2'd1,
      SONUC    = 2'd2
   } durum_e;

   localparam logic [6:0] CUSTOM0 = 7'b0001011;
   localparam logic [2:0] F_LDW   = 3'b000;
   localparam logic [2:0] F_CLRW  = 3'b001;
   localparam logic [2:0] F_LDX   = 3'b010;
   localparam logic [2:0] F_CLRX  = 3'b011;
   localparam logic [2:0] F_RUN   = 3'b100;

   durum_e      durum_r, durum_s;
   logic [4:0]  rd_r, rd_s;
   logic        kabul_s;
   logic        yuk_sil_s;
   logic [2:0]  funct3_s;
   logic        iki_kelime_s;

   logic        blok_aktif_r, blok_aktif_s;
   logic        filtre_rs1_en_r, filtre_rs1_en_s;
   logic        filtre_rs2_en_r, filtre_rs2_en_s;
   logic        filtre_sil_r, filtre_sil_s;
   logic        veri_rs1_en_r, veri_rs1_en_s;
   logic        veri_rs2_en_r, veri_rs2_en_s;
   logic        veri_sil_r, veri_sil_s;
   logic        conv_yap_en_r, conv_yap_en_s;
   logic [31:0] rs1_veri_r, rs1_veri_s;
   logic [31:0] rs2_veri_r, rs2_veri_s;
   logic        stall_r, stall_s;
   logic        yaz_gecerli_r, yaz_gecerli_s;
   logic [4:0]  yaz_adres_r, yaz_adres_s;
   logic [31:0] yaz_veri_r, yaz_veri_s;
   logic        gecersiz_r, gecersiz_s;
   logic        unused_komut_s;

`ifdef YZH_ZAMAN_ASIMI_EN
   localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);
   localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);
   localparam logic [SAYAC_W-1:0] SAYAC_BIR = SAYAC_W'(1);
   logic [SAYAC_W-1:0] sayac_r, sayac_s;
`else
   logic [31:0] unused_zaman_s;
   assign unused_zaman_s = 32'(ZAMAN_ASIMI);
`endif

   assign funct3_s       = komut_i[14:12];
   assign iki_kelime_s   = komut_i[25];
   assign kabul_s        = (durum_r == BOSTA) && komut_gecerli_i &&
                           (komut_i[6:0] == CUSTOM0) && !durdur_i;
   assign unused_komut_s = ^{komut_i[31:26], komut_i[24:15]};

   // Next state and next registered-output values
   always_comb begin
      durum_s         = durum_r;
      rd_s            = rd_r;
      yuk_sil_s       = 1'b0;
      filtre_rs1_en_s = 1'b0;
      filtre_rs2_en_s = 1'b0;
      filtre_sil_s    = 1'b0;
      veri_rs1_en_s   = 1'b0;
      veri_rs2_en_s   = 1'b0;
      veri_sil_s      = 1'b0;
      gecersiz_s      = 1'b0;
      yaz_veri_s      = 32'h0000_0000;
`ifdef YZH_ZAMAN_ASIMI_EN
      sayac_s         = sayac_r;
`endif
      case (durum_r)
         BOSTA: begin
            if (kabul_s) begin
               case (funct3_s)
                  F_LDW: begin
                     filtre_rs1_en_s = 1'b1;
                     filtre_rs2_en_s = iki_kelime_s;
                     yuk_sil_s       = 1'b1;
                  end
                  F_CLRW: begin
                     filtre_sil_s = 1'b1;
                     yuk_sil_s    = 1'b1;
                  end
                  F_LDX: begin
                     veri_rs1_en_s = 1'b1;
                     veri_rs2_en_s = iki_kelime_s;
                     yuk_sil_s     = 1'b1;
                  end
                  F_CLRX: begin
                     veri_sil_s = 1'b1;
                     yuk_sil_s  = 1'b1;
                  end
                  F_RUN: begin
                     durum_s = CALISTIR;
                     rd_s    = komut_i[11:7];
`ifdef YZH_ZAMAN_ASIMI_EN
                     sayac_s = {SAYAC_W{1'b0}};
`endif
                  end
                  default: gecersiz_s = 1'b1;
               endcase
            end else begin
               durum_s = BOSTA;
            end
         end
         CALISTIR: begin
            // a ready result wins even while frozen; only the timeout counter honours durdur_i
            if (conv_hazir_i) begin
               durum_s    = SONUC;
               yaz_veri_s = conv_sonuc_i;
            end
`ifdef YZH_ZAMAN_ASIMI_EN
            else if (durdur_i) begin
               durum_s = CALISTIR;
            end else if (sayac_r == SAYAC_SON) begin
               durum_s    = SONUC;
               yaz_veri_s = 32'hFFFF_FFFF;
            end else begin
               sayac_s = sayac_r + SAYAC_BIR;
            end
`else
            else begin
               durum_s = CALISTIR;
            end
`endif
         end
         SONUC: begin
            if (durdur_i) begin
               durum_s    = SONUC;
               yaz_veri_s = yaz_veri_r;
            end else begin
               durum_s = BOSTA;
            end
         end
         default: durum_s = BOSTA;
      endcase

      if (yuk_sil_s) begin
         rs1_veri_s = rs1_veri_i;
         rs2_veri_s = rs2_veri_i;
      end else begin
         rs1_veri_s = 32'h0000_0000;
         rs2_veri_s = 32'h0000_0000;
      end
      conv_yap_en_s = (durum_s == CALISTIR);
      stall_s       = (durum_s == CALISTIR);
      blok_aktif_s  = yuk_sil_s || (durum_s == CALISTIR);
      yaz_gecerli_s = (durum_s == SONUC);
      yaz_adres_s   = (durum_s == SONUC) ? rd_s : 5'd0;
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_r         <= BOSTA;
         rd_r            <= 5'd0;
         blok_aktif_r    <= 1'b0;
         filtre_rs1_en_r <= 1'b0;
         filtre_rs2_en_r <= 1'b0;
         filtre_sil_r    <= 1'b0;
         veri_rs1_en_r   <= 1'b0;
         veri_rs2_en_r   <= 1'b0;
         veri_sil_r      <= 1'b0;
         conv_yap_en_r   <= 1'b0;
         rs1_veri_r      <= 32'h0000_0000;
         rs2_veri_r      <= 32'h0000_0000;
         stall_r         <= 1'b0;
         yaz_gecerli_r   <= 1'b0;
         yaz_adres_r     <= 5'd0;
         yaz_veri_r      <= 32'h0000_0000;
         gecersiz_r      <= 1'b0;
`ifdef YZH_ZAMAN_ASIMI_EN
         sayac_r         <= {SAYAC_W{1'b0}};
`endif
      end else begin
         durum_r         <= durum_s;
         rd_r            <= rd_s;
         blok_aktif_r    <= blok_aktif_s;
         filtre_rs1_en_r <= filtre_rs1_en_s;
         filtre_rs2_en_r <= filtre_rs2_en_s;
         filtre_sil_r    <= filtre_sil_s;
         veri_rs1_en_r   <= veri_rs1_en_s;
         veri_rs2_en_r   <= veri_rs2_en_s;
         veri_sil_r      <= veri_sil_s;
         conv_yap_en_r   <= conv_yap_en_s;
         rs1_veri_r      <= rs1_veri_s;
         rs2_veri_r      <= rs2_veri_s;
         stall_r         <= stall_s;
         yaz_gecerli_r   <= yaz_gecerli_s;
         yaz_adres_r     <= yaz_adres_s;
         yaz_veri_r      <= yaz_veri_s;
         gecersiz_r      <= gecersiz_s;
`ifdef YZH_ZAMAN_ASIMI_EN
         sayac_r         <= sayac_s;
`endif
      end
   end

   assign blok_aktif_o     = blok_aktif_r;
   assign filtre_rs1_en_o  = filtre_rs1_en_r;
   assign filtre_rs2_en_o  = filtre_rs2_en_r;
   assign filtre_sil_o     = filtre_sil_r;
   assign veri_rs1_en_o    = veri_rs1_en_r;
   assign veri_rs2_en_o    = veri_rs2_en_r;
   assign veri_sil_o       = veri_sil_r;
   assign conv_yap_en_o    = conv_yap_en_r;
   assign rs1_veri_o       = rs1_veri_r;
   assign rs2_veri_o       = rs2_veri_r;
   assign durdur_o         = durdur_i;
   assign stall_o          = stall_r;
   assign yaz_gecerli_o    = yaz_gecerli_r;
   assign yaz_adres_o      = yaz_adres_r;
   assign yaz_veri_o       = yaz_veri_r;
   assign gecersiz_komut_o = gecersiz_r;

endmodule

// File: tb/tb_yzh_komut_denetleyici.sv
// Self-checking bench for yzh_komut_denetleyici: vector table plus hand-written run sequences,
// expected outputs queued at drive time and popped one cycle later.
module tb_yzh_komut_denetleyici;

   logic        clk_i = 1'b0;
   logic        rst_i, durdur_i, komut_gecerli_i, conv_hazir_i;
   logic [31:0] komut_i, rs1_veri_i, rs2_veri_i, conv_sonuc_i;
   logic        blok_aktif_o, filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o;
   logic        veri_rs1_en_o, veri_rs2_en_o, veri_sil_o, conv_yap_en_o;
   logic [31:0] rs1_veri_o, rs2_veri_o, yaz_veri_o;
   logic        durdur_o, stall_o, yaz_gecerli_o, gecersiz_komut_o;
   logic [4:0]  yaz_adres_o;

   always #5 clk_i = ~clk_i;

   yzh_komut_denetleyici #(.ZAMAN_ASIMI(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i),
      .komut_gecerli_i(komut_gecerli_i), .komut_i(komut_i),
      .rs1_veri_i(rs1_veri_i), .rs2_veri_i(rs2_veri_i),
      .conv_sonuc_i(conv_sonuc_i), .conv_hazir_i(conv_hazir_i),
      .blok_aktif_o(blok_aktif_o), .filtre_rs1_en_o(filtre_rs1_en_o),
      .filtre_rs2_en_o(filtre_rs2_en_o), .filtre_sil_o(filtre_sil_o),
      .veri_rs1_en_o(veri_rs1_en_o), .veri_rs2_en_o(veri_rs2_en_o),
      .veri_sil_o(veri_sil_o), .conv_yap_en_o(conv_yap_en_o),
      .rs1_veri_o(rs1_veri_o), .rs2_veri_o(rs2_veri_o), .durdur_o(durdur_o),
      .stall_o(stall_o), .yaz_gecerli_o(yaz_gecerli_o), .yaz_adres_o(yaz_adres_o),
      .yaz_veri_o(yaz_veri_o), .gecersiz_komut_o(gecersiz_komut_o)
   );

   typedef struct packed {
      logic        blok, f1, f2, fs, v1, v2, vs, yap;
      logic [31:0] r1, r2;
      logic        stall, yg;
      logic [4:0]  ya;
      logic [31:0] yv;
      logic        gec, dur;
   } cikis_t;

   typedef struct {
      logic        rst, gecerli;
      logic [31:0] komut, rs1, rs2;
      logic        dur, hazir;
      logic [31:0] sonuc;
   } giris_t;

   typedef struct {
      string  ad;
      giris_t g;
      cikis_t c;
   } vektor_t;

   cikis_t  beklenen_q[$];
   vektor_t tablo[$];
   int      total = 0;
   int      bad   = 0;

   function automatic logic [31:0] komut(input logic [2:0] f3, input logic b25, input logic [4:0] rd);
      return {6'd0, b25, 5'd2, 5'd1, f3, rd, 7'b0001011};
   endfunction

   function automatic giris_t gir(input logic gec, input logic [31:0] k, input logic [31:0] a,
                                  input logic [31:0] b, input logic dur, input logic hz,
                                  input logic [31:0] s);
      giris_t g;
      g.rst = 1'b0; g.gecerli = gec; g.komut = k; g.rs1 = a; g.rs2 = b;
      g.dur = dur; g.hazir = hz; g.sonuc = s;
      return g;
   endfunction

   function automatic cikis_t sifir();
      cikis_t c;
      c = '0;
      return c;
   endfunction

   function automatic cikis_t calis();
      cikis_t c;
      c = '0; c.blok = 1'b1; c.yap = 1'b1; c.stall = 1'b1;
      return c;
   endfunction

   function automatic cikis_t sonuc_c(input logic [4:0] adr, input logic [31:0] veri);
      cikis_t c;
      c = '0; c.yg = 1'b1; c.ya = adr; c.yv = veri;
      return c;
   endfunction

   task automatic ekle(input string ad, input giris_t g, input cikis_t c);
      vektor_t v;
      v.ad = ad; v.g = g; v.c = c;
      tablo.push_back(v);
   endtask

   task automatic gozle(input string ad);
      cikis_t gercek, bek;
      gercek = {blok_aktif_o, filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o,
                veri_rs1_en_o, veri_rs2_en_o, veri_sil_o, conv_yap_en_o,
                rs1_veri_o, rs2_veri_o, stall_o, yaz_gecerli_o, yaz_adres_o,
                yaz_veri_o, gecersiz_komut_o, durdur_o};
      total++;
      if (beklenen_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, got=%h", ad, gercek);
      end else begin
         bek = beklenen_q.pop_front();
         if (gercek !== bek) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", ad, gercek, bek);
         end
      end
   endtask

   task automatic adim(input string ad, input giris_t g, input cikis_t c);
      cikis_t e;
      rst_i = g.rst; komut_gecerli_i = g.gecerli; komut_i = g.komut;
      rs1_veri_i = g.rs1; rs2_veri_i = g.rs2; durdur_i = g.dur;
      conv_hazir_i = g.hazir; conv_sonuc_i = g.sonuc;
      e = c;
      e.dur = g.dur;
      beklenen_q.push_back(e);
      @(posedge clk_i);
      #1;
      gozle(ad);
   endtask

   task automatic run_kabul(input logic [4:0] rd);
      adim("run_kabul", gir(1'b1, komut(3'b100, 1'b0, rd), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), calis());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      giris_t      g;
      cikis_t      c;
      logic [31:0] k;

      rst_i = 1'b1; komut_gecerli_i = 1'b0; komut_i = 32'h0; rs1_veri_i = 32'h0;
      rs2_veri_i = 32'h0; durdur_i = 1'b0; conv_hazir_i = 1'b0; conv_sonuc_i = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;

      g = gir(1'b1, komut(3'b000, 1'b1, 5'd0), 32'h11, 32'h22, 1'b0, 1'b0, 32'h0);
      g.rst = 1'b1;
      adim("reset", g, sifir());

      c = sifir(); c.blok = 1'b1; c.f1 = 1'b1; c.f2 = 1'b1; c.r1 = 32'h11; c.r2 = 32'h22;
      ekle("ldw_iki", gir(1'b1, komut(3'b000, 1'b1, 5'd0), 32'h11, 32'h22, 1'b0, 1'b0, 32'h0), c);
      ekle("ldw_sonrasi", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());
      c = sifir(); c.blok = 1'b1; c.f1 = 1'b1; c.r1 = 32'hA; c.r2 = 32'hB;
      ekle("ldw_tek", gir(1'b1, komut(3'b000, 1'b0, 5'd0), 32'hA, 32'hB, 1'b0, 1'b0, 32'h0), c);
      c = sifir(); c.blok = 1'b1; c.fs = 1'b1; c.r1 = 32'h3; c.r2 = 32'h4;
      ekle("clrw", gir(1'b1, komut(3'b001, 1'b0, 5'd0), 32'h3, 32'h4, 1'b0, 1'b0, 32'h0), c);
      c = sifir(); c.blok = 1'b1; c.v1 = 1'b1; c.v2 = 1'b1; c.r1 = 32'h55; c.r2 = 32'h66;
      ekle("ldx_iki", gir(1'b1, komut(3'b010, 1'b1, 5'd0), 32'h55, 32'h66, 1'b0, 1'b0, 32'h0), c);
      c = sifir(); c.blok = 1'b1; c.vs = 1'b1; c.r1 = 32'h7; c.r2 = 32'h8;
      ekle("clrx", gir(1'b1, komut(3'b011, 1'b0, 5'd0), 32'h7, 32'h8, 1'b0, 1'b0, 32'h0), c);
      c = sifir(); c.gec = 1'b1;
      ekle("gecersiz_110", gir(1'b1, komut(3'b110, 1'b0, 5'd0), 32'h9, 32'h9, 1'b0, 1'b0, 32'h0), c);
      ekle("gecersiz_sonra", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());
      ekle("gecersiz_101", gir(1'b1, komut(3'b101, 1'b1, 5'd3), 32'h9, 32'h9, 1'b0, 1'b0, 32'h0), c);
      ekle("gecersiz_111", gir(1'b1, komut(3'b111, 1'b0, 5'd3), 32'h9, 32'h9, 1'b0, 1'b0, 32'h0), c);
      k = komut(3'b000, 1'b1, 5'd0);
      k[6:0] = 7'b0110011;
      ekle("ozel_degil", gir(1'b1, k, 32'h11, 32'h22, 1'b0, 1'b0, 32'h0), sifir());
      ekle("durdur_kabul_yok", gir(1'b1, komut(3'b000, 1'b0, 5'd0), 32'h11, 32'h22, 1'b1, 1'b0, 32'h0), sifir());
      ekle("gecerli_degil", gir(1'b0, komut(3'b010, 1'b0, 5'd0), 32'h11, 32'h22, 1'b0, 1'b0, 32'h0), sifir());
      ekle("hazir_bosta", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234), sifir());
      for (int i = 1; i <= 4; i++) begin
         c = sifir(); c.blok = 1'b1; c.v1 = 1'b1; c.r1 = 32'(i); c.r2 = 32'h0;
         ekle("ldx_ardisik", gir(1'b1, komut(3'b010, 1'b0, 5'd0), 32'(i), 32'h0, 1'b0, 1'b0, 32'h0), c);
      end

      for (int i = 0; i < tablo.size(); i++) begin
         adim(tablo[i].ad, tablo[i].g, tablo[i].c);
      end

      // run rd=5, result 6 cycles after acceptance; the held ldx is not taken meanwhile
      run_kabul(5'd5);
      for (int i = 0; i < 5; i++) begin
         adim("run_calis", gir(1'b1, komut(3'b010, 1'b0, 5'd0), 32'h77, 32'h0, 1'b0, 1'b0, 32'h0), calis());
      end
      adim("run_sonuc", gir(1'b1, komut(3'b010, 1'b0, 5'd0), 32'h77, 32'h0, 1'b0, 1'b1, 32'h1234),
           sonuc_c(5'd5, 32'h1234));
      adim("run_cikis", gir(1'b1, komut(3'b010, 1'b0, 5'd0), 32'h77, 32'h0, 1'b0, 1'b0, 32'h0), sifir());
      c = sifir(); c.blok = 1'b1; c.v1 = 1'b1; c.r1 = 32'h77;
      adim("run_bekleyen_ldx", gir(1'b1, komut(3'b010, 1'b0, 5'd0), 32'h77, 32'h0, 1'b0, 1'b0, 32'h0), c);

      // same run, durdur held 3 cycles in SONUC
      run_kabul(5'd5);
      for (int i = 0; i < 5; i++) begin
         adim("run2_calis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), calis());
      end
      adim("run2_sonuc", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234), sonuc_c(5'd5, 32'h1234));
      for (int i = 0; i < 3; i++) begin
         adim("run2_durdur_tut", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h9999), sonuc_c(5'd5, 32'h1234));
      end
      adim("run2_cikis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());

      // durdur in CALISTIR: controls held, conv_hazir_i still taken
      run_kabul(5'd3);
      adim("calis_durdur", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), calis());
      adim("calis_durdur_hazir", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBEEF), sonuc_c(5'd3, 32'hBEEF));
      adim("calis_durdur_cikis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());

      // minimum run with rd=0
      run_kabul(5'd0);
      adim("min_run_sonuc", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE), sonuc_c(5'd0, 32'hCAFE));
      adim("min_run_cikis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());

      // reset mid-run aborts with no writeback
      run_kabul(5'd7);
      adim("rst_calis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), calis());
      g = gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555);
      g.rst = 1'b1;
      adim("rst_ortada", g, sifir());
      adim("rst_sonrasi_hazir", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555), sifir());

`ifdef YZH_ZAMAN_ASIMI_EN
      run_kabul(5'd4);
      for (int i = 0; i < 7; i++) begin
         adim("zaman_calis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), calis());
      end
      adim("zaman_asimi", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sonuc_c(5'd4, 32'hFFFF_FFFF));
      adim("zaman_cikis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());
`else
      run_kabul(5'd4);
      for (int i = 0; i < 20; i++) begin
         adim("sonsuz_bekle", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), calis());
      end
      adim("sonsuz_sonuc", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD), sonuc_c(5'd4, 32'h0BAD));
      adim("sonsuz_cikis", gir(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), sifir());
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
